// File: rtl/gpr_sb.sv
// General-purpose register file with hardwired zero, overflow flag register, write-to-read
// bypass and a per-register busy scoreboard for stalling on pending writebacks.
module gpr_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned FLAG_REG = 30,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ovf_en,
    input  logic              ovf,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              sb_err
);

    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam int unsigned CW   = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] FLAG_A = ADDR_W'(FLAG_REG);
    localparam logic [ADDR_W-1:0] ZERO_A = '0;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busyNext;
    logic [NREG-1:0]   clrMask;
    logic [NREG-1:0]   setMask;
    logic [CW-1:0]     cntReg;
    logic [CW-1:0]     cntNext;
    logic              errReg;

    logic wrSuppress;
    logic wrEffective;
    logic flagUpd;
    logic flagWrite;
    logic rsvAccept;
    logic setInc;
    logic clrDec;

    // Write qualification: a trapping overflow drops the data write but still updates the flag.
    always_comb begin
        wrSuppress  = wr_en & ovf_en & ovf;
        wrEffective = wr_en & (wr_addr != ZERO_A) & ~wrSuppress;
        flagUpd     = wr_en & ovf_en;
        flagWrite   = flagUpd & ~(wrEffective & (wr_addr == FLAG_A));
    end

    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = regs[addr];
        if (addr == ZERO_A) begin
            val = '0;
        end else if (BYPASS) begin
            if (wrEffective && (wr_addr == addr)) begin
                val = wr_data;
            end else if ((addr == FLAG_A) && flagUpd) begin
                val = DATA_W'(ovf);
            end
        end
        return val;
    endfunction

    always_comb begin
        rd_data1 = readPort(rd_addr1);
        rd_data2 = readPort(rd_addr2);
        rd_busy1 = busy[rd_addr1] & ~(BYPASS & wr_en & (wr_addr == rd_addr1));
        rd_busy2 = busy[rd_addr2] & ~(BYPASS & wr_en & (wr_addr == rd_addr2));
    end

    // Scoreboard: a same-cycle release of the target register lets a new reservation through.
    always_comb begin
        rsv_ok    = rsv_en & ((rsv_addr == ZERO_A) | ~busy[rsv_addr] |
                              (wr_en & (wr_addr == rsv_addr)));
        rsvAccept = rsv_ok & (rsv_addr != ZERO_A);
        clrMask   = '0;
        setMask   = '0;
        if (wr_en) begin
            clrMask = NREG'(1) << wr_addr;
        end
        if (rsvAccept) begin
            setMask = NREG'(1) << rsv_addr;
        end
        busyNext    = ((busy & ~clrMask) | setMask) & ~NREG'(1);
        setInc      = rsvAccept & ~busy[rsv_addr];
        clrDec      = wr_en & (wr_addr != ZERO_A) & busy[wr_addr] &
                      ~(rsvAccept & (rsv_addr == wr_addr));
        cntNext     = cntReg + CW'(setInc) - CW'(clrDec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
            busy   <= '0;
            cntReg <= '0;
            errReg <= 1'b0;
        end else begin
            if (flagWrite) begin
                regs[FLAG_A] <= DATA_W'(ovf);
            end
            if (wrEffective) begin
                regs[wr_addr] <= wr_data;
            end
            busy   <= busyNext;
            cntReg <= cntNext;
            if (rsv_en && !rsv_ok) begin
                errReg <= 1'b1;
            end
        end
    end

    assign busy_cnt = cntReg;
    assign sb_err   = errReg;

endmodule

// File: tb/tb_gpr_sb.sv
// Directed vector bench for gpr_sb; a BYPASS=0 twin shares all inputs to check the
// no-forwarding read path alongside the bypassing instance.
module tb_gpr_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic [31:0] wr_data;
    logic        wr_en, ovf_en, ovf, rsv_en;
    logic [31:0] rd_data1, rd_data2, nbData1, nbData2;
    logic        rd_busy1, rd_busy2, nbBusy1, nbBusy2;
    logic        rsv_ok, nbRsvOk, sb_err, nbErr;
    logic [5:0]  busy_cnt, nbCnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpr_sb #(.DATA_W(32), .ADDR_W(5), .FLAG_REG(30), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ovf_en(ovf_en), .ovf(ovf),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .busy_cnt(busy_cnt),
        .sb_err(sb_err)
    );

    gpr_sb #(.DATA_W(32), .ADDR_W(5), .FLAG_REG(30), .BYPASS(1'b0)) dutNb (
        .clk(clk), .rst(rst), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(nbData1), .rd_data2(nbData2), .rd_busy1(nbBusy1), .rd_busy2(nbBusy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ovf_en(ovf_en), .ovf(ovf),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(nbRsvOk), .busy_cnt(nbCnt),
        .sb_err(nbErr)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        oe;
        logic        ov;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] enb2;
        logic        b1;
        logic        b2;
        logic        ok;
        logic [5:0]  cnt;
        logic        err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic oe, input logic ov, input logic re,
                                input logic [4:0] ra, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] enb2, input logic b1, input logic b2,
                                input logic ok, input logic [5:0] cnt, input logic err);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.oe = oe; v.ov = ov; v.re = re; v.ra = ra;
        v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2; v.enb2 = enb2; v.b1 = b1; v.b2 = b2;
        v.ok = ok; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; ovf_en = 1'b0; ovf = 1'b0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0;
        idle();

        //      we wa  wd            oe ov re ra  a1  a2  e1            e2            enb2          b1 b2 ok cnt err
        vq.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0,  5,  0, 32'hDEADBEEF, 0,            0,            0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 32'h1,        0, 0, 0, 0,  5,  0, 32'hDEADBEEF, 0,            0,            0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,            0, 0, 0, 0,  0,  5, 0,            32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 7, 32'h1234,     0, 0, 0, 0,  5,  7, 32'hDEADBEEF, 32'h1234,     0,            0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,            0, 0, 0, 0,  7,  7, 32'h1234,     32'h1234,     32'h1234,     0, 0, 0, 0, 0));
        vq.push_back(mk(1, 8, 32'h55,       1, 1, 0, 0,  8, 30, 0,            1,            0,            0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,            0, 0, 0, 0,  8, 30, 0,            1,            1,            0, 0, 0, 0, 0));
        vq.push_back(mk(1, 8, 32'h3,        1, 0, 0, 0,  8, 30, 32'h3,        0,            1,            0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,            0, 0, 0, 0,  8, 30, 32'h3,        0,            0,            0, 0, 0, 0, 0));
        vq.push_back(mk(1, 30, 32'hAA,      1, 0, 0, 0, 30, 30, 32'hAA,       32'hAA,       0,            0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,            1, 1, 0, 0, 30,  8, 32'hAA,       32'h3,        32'h3,        0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 0,            0, 0, 1, 9,  9, 30, 0,            32'hAA,       32'hAA,       0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0, 0,            0, 0, 0, 0,  9,  0, 0,            0,            0,            1, 0, 0, 1, 0));
        vq.push_back(mk(0, 0, 0,            0, 0, 1, 9,  9,  0, 0,            0,            0,            1, 0, 0, 1, 0));
        vq.push_back(mk(0, 0, 0,            0, 0, 0, 0,  9,  0, 0,            0,            0,            1, 0, 0, 1, 1));
        vq.push_back(mk(1, 9, 32'h77,       0, 0, 1, 9,  9,  9, 32'h77,       32'h77,       0,            0, 0, 1, 1, 1));
        vq.push_back(mk(0, 0, 0,            0, 0, 0, 0,  9,  9, 32'h77,       32'h77,       32'h77,       1, 1, 0, 1, 1));
        vq.push_back(mk(1, 9, 32'h88,       0, 0, 1, 4,  4,  9, 0,            32'h88,       32'h77,       0, 0, 1, 1, 1));
        vq.push_back(mk(0, 0, 0,            0, 0, 0, 0,  4,  9, 0,            32'h88,       32'h88,       1, 0, 0, 1, 1));
        vq.push_back(mk(0, 0, 0,            0, 0, 1, 0,  0,  9, 0,            32'h88,       32'h88,       0, 0, 1, 1, 1));
        vq.push_back(mk(1, 4, 32'h44,       0, 0, 0, 0,  4,  9, 32'h44,       32'h88,       32'h88,       0, 0, 0, 1, 1));
        vq.push_back(mk(0, 0, 0,            0, 0, 0, 0,  4,  9, 32'h44,       32'h88,       32'h88,       0, 0, 0, 0, 1));

        // Reset state
        #12;
        rd_addr1 = 5'd5; rd_addr2 = 5'd30;
        #1;
        chk("rst_rd1", rd_data1, 32'h0);
        chk("rst_rd2", rd_data2, 32'h0);
        chk("rst_cnt", 32'(busy_cnt), 32'h0);
        chk("rst_err", 32'(sb_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[i]) begin
            @(negedge clk);
            wr_en = vq[i].we; wr_addr = vq[i].wa; wr_data = vq[i].wd;
            ovf_en = vq[i].oe; ovf = vq[i].ov; rsv_en = vq[i].re; rsv_addr = vq[i].ra;
            rd_addr1 = vq[i].a1; rd_addr2 = vq[i].a2;
            #2;
            chk($sformatf("v%0d_rd1", i), rd_data1, vq[i].e1);
            chk($sformatf("v%0d_rd2", i), rd_data2, vq[i].e2);
            chk($sformatf("v%0d_nb_rd2", i), nbData2, vq[i].enb2);
            chk($sformatf("v%0d_busy1", i), 32'(rd_busy1), 32'(vq[i].b1));
            chk($sformatf("v%0d_busy2", i), 32'(rd_busy2), 32'(vq[i].b2));
            chk($sformatf("v%0d_rsv_ok", i), 32'(rsv_ok), 32'(vq[i].ok));
            chk($sformatf("v%0d_cnt", i), 32'(busy_cnt), 32'(vq[i].cnt));
            chk($sformatf("v%0d_err", i), 32'(sb_err), 32'(vq[i].err));
        end

        // Fill the scoreboard: x4 and x9 are free again, so every x1..x31 reservation succeeds
        @(negedge clk);
        idle();
        #2;
        chk("pre_fill_cnt", 32'(busy_cnt), 32'h0);
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            rsv_en = 1'b1; rsv_addr = 5'(i);
            #2;
            chk($sformatf("fill_ok_x%0d", i), 32'(rsv_ok), 32'h1);
        end
        @(negedge clk);
        idle();
        rd_addr1 = 5'd17; rd_addr2 = 5'd30;
        #2;
        chk("full_cnt", 32'(busy_cnt), 32'd31);
        chk("full_busy1", 32'(rd_busy1), 32'h1);
        chk("full_busy2", 32'(rd_busy2), 32'h1);
        chk("full_err", 32'(sb_err), 32'h1);

        // Asynchronous reset between clock edges
        rst = 1'b1;
        #1;
        chk("arst_cnt", 32'(busy_cnt), 32'h0);
        chk("arst_err", 32'(sb_err), 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            #0.1;
            chk($sformatf("arst_x%0d", i), rd_data1, 32'h0);
            chk($sformatf("arst_busy_x%0d", i), 32'(rd_busy1), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Writeback after reset writes normally; release of a non-busy register keeps count at 0
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE0003;
        @(negedge clk);
        idle();
        rd_addr1 = 5'd3;
        #2;
        chk("post_rst_x3", rd_data1, 32'hCAFE0003);
        chk("post_rst_nb_x3", nbData1, 32'hCAFE0003);
        chk("post_rst_cnt", 32'(busy_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
